io_intr_ctrl: RTL and testbench
===============================

IO_INTR_CTRL -- requirements
Module: io_intr_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'hF0, meaning port ID of register 0; registers occupy BASE_ADDR..BASE_ADDR+3.
REQ-002 SHALL have parameter HOLDOFF, default 2, meaning number of cycles INTR is forced low after an acknowledge; legal range 1..15.
REQ-003 SHALL have port CLK  in  1  system clock; all flops on the rising edge.
REQ-004 SHALL have port RESET_N  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port IRQ  in  8  asynchronous interrupt sources, rising-edge sensitive.
REQ-006 SHALL have port PORT_ID  in  8  I/O port address from the MCU.
REQ-007 SHALL have port OUT_PORT  in  8  write data from the MCU.
REQ-008 SHALL have port IO_STRB  in  1  one-cycle write strobe from the MCU OUT instruction.
REQ-009 SHALL have port IN_PORT  out  8  read data: the register selected by PORT_ID, or 8'h00 if no register is selected (OR-bus safe).
REQ-010 SHALL have port INTR  out  1  interrupt request to the MCU control unit.

Function
REQ-011 Each IRQ bit SHALL pass a 2-flop synchronizer; a rising edge SHALL be detected on the synchronized value against a third flop; edge-to-PENDING-set latency SHALL be 3 CLK cycles.
REQ-012 Register map: BASE+0 MASK (R/W, 1 = enabled); BASE+1 PENDING (read; write-1-to-clear); BASE+2 ID (read-only); BASE+3 CTRL (R/W, bit0 GEN global enable, bits 7:1 read as 0).
REQ-013 A write SHALL occur only in a cycle where IO_STRB=1 and PORT_ID matches; writes to ID SHALL be ignored.
REQ-014 The read path SHALL be combinational from PORT_ID, independent of IO_STRB.
REQ-015 ID SHALL read as {GEN_ACTIVE, 4'b0, idx[2:0]}, where idx is the lowest set bit index of PENDING&MASK (bit 0 is highest priority) and bit7 is 1 only if PENDING&MASK is nonzero; otherwise ID SHALL read 8'h00.
REQ-016 If an edge event and a W1C on the same PENDING bit coincide, set SHALL win.
REQ-017 Edges SHALL set PENDING regardless of MASK; MASK gates only INTR and ID.
REQ-018 FSM states: IDLE, FIRE, HOLD.
REQ-019 IDLE -> FIRE when GEN=1 and (PENDING&MASK)!=0; INTR SHALL be registered and rise the cycle after entry into FIRE.
REQ-020 In FIRE, INTR SHALL be 1; FIRE -> HOLD when (PENDING&MASK)==0 or GEN==0; the HOLD counter SHALL load HOLDOFF.
REQ-021 In HOLD, INTR SHALL be 0 and the counter SHALL decrement each cycle; HOLD -> IDLE when the counter reaches 1, regardless of new pending events, which remain latched.
REQ-022 Writing MASK to clear the active bit SHALL count as an acknowledge per REQ-020.
REQ-023 INTR SHALL never be 1 in IDLE or HOLD.

Reset
REQ-024 While RESET_N=0: MASK=0, PENDING=0, GEN=0, synchronizer and edge flops=0, FSM=IDLE, counter=0, INTR=0; IN_PORT SHALL follow REQ-009 using the reset register values.
REQ-025 An IRQ line held high through the release of reset SHALL produce one edge event, at 3 cycles after release.
REQ-026 Reset asserted in FIRE or HOLD SHALL return to IDLE immediately, with no INTR glitch after release.

Verification
REQ-027 Scenario: GEN=1, MASK=8'h04, pulse IRQ[2] -> PENDING=8'h04 3 cycles after edge; INTR=1 next cycle; ID=8'h82.
REQ-028 Scenario: IRQ[5] and IRQ[1] fire together, MASK=8'hFF -> ID=8'h81; W1C 8'h02 -> ID=8'h85; INTR stays 1; W1C 8'h20 -> INTR=0 for exactly HOLDOFF=2 cycles, then IDLE.
REQ-029 Scenario: IRQ[3] edge detected in the same cycle as a W1C of 8'h08 -> PENDING[3] remains 1.
REQ-030 Scenario: MASK=0, IRQ[7] pulse -> PENDING=8'h80, INTR=0, ID=8'h00; then write MASK=8'h80 -> INTR=1 within 2 cycles.
REQ-031 Scenario: PORT_ID=8'h10, IO_STRB=1, OUT_PORT=8'hFF -> no register changes; IN_PORT=8'h00.
REQ-032 Scenario: RESET_N pulled low during FIRE -> INTR=0 asynchronously; after release INTR stays 0 until a new enabled edge occurs.

Source files
------------

// File: rtl/io_intr_ctrl.sv
// Eight-source edge-triggered interrupt controller on an MCU port-I/O bus.
// Four registers (MASK, PENDING, ID, CTRL) and a FIRE/HOLD request sequencer.
module io_intr_ctrl #(
    parameter logic [7:0]  BASE_ADDR = 8'hF0,
    parameter int unsigned HOLDOFF   = 2     // legal range 1..15
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] IRQ,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] IN_PORT,
    output logic       INTR
);

    localparam logic [1:0] OFS_MASK = 2'd0;
    localparam logic [1:0] OFS_PEND = 2'd1;
    localparam logic [1:0] OFS_ID   = 2'd2;
    localparam logic [1:0] OFS_CTRL = 2'd3;
    localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;
    logic [7:0] edge_q,  edge_d;
    logic [7:0] mask_q,  mask_d;
    logic [7:0] pend_q,  pend_d;
    logic       gen_q,   gen_d;
    state_t     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       intr_q,  intr_d;

    logic [7:0] addr_off;
    logic       addr_hit;
    logic [1:0] reg_sel;
    logic       wr_mask, wr_pend, wr_ctrl;
    logic [7:0] rise;
    logic [7:0] active;
    logic       any_active;
    logic [2:0] idx;
    logic [7:0] id_val;
    logic [7:0] rd_data;

    // Offset from the base wraps modulo 256, so any BASE_ADDR alignment works.
    always_comb begin
        addr_off = PORT_ID - BASE_ADDR;
        addr_hit = (addr_off[7:2] == 6'd0);
        reg_sel  = addr_off[1:0];
        wr_mask  = IO_STRB && addr_hit && (reg_sel == OFS_MASK);
        wr_pend  = IO_STRB && addr_hit && (reg_sel == OFS_PEND);
        wr_ctrl  = IO_STRB && addr_hit && (reg_sel == OFS_CTRL);
    end

    always_comb begin
        sync1_d = IRQ;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
        rise    = sync2_q & ~edge_q;
    end

    // A new edge is OR-ed in after the clear, so set beats write-1-to-clear.
    always_comb begin
        mask_d = wr_mask ? OUT_PORT : mask_q;
        gen_d  = wr_ctrl ? OUT_PORT[0] : gen_q;
        pend_d = (pend_q & ~(wr_pend ? OUT_PORT : 8'h00)) | rise;
    end

    always_comb begin
        active     = pend_q & mask_q;
        any_active = |active;
        idx        = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) begin
                idx = 3'(i);
            end
        end
        id_val = any_active ? {1'b1, 4'b0000, idx} : 8'h00;
    end

    always_comb begin
        rd_data = 8'h00;
        if (addr_hit) begin
            case (reg_sel)
                OFS_MASK: rd_data = mask_q;
                OFS_PEND: rd_data = pend_q;
                OFS_ID:   rd_data = id_val;
                OFS_CTRL: rd_data = {7'b0000000, gen_q};
                default:  rd_data = 8'h00;
            endcase
        end
    end

    assign IN_PORT = rd_data;
    assign INTR    = intr_q;

    // Clearing the active source by W1C, MASK or GEN all look the same here:
    // the sequencer only sees the enabled set going empty.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (gen_q && any_active) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (!any_active || !gen_q) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        intr_d = (state_d == ST_FIRE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
            edge_q  <= 8'h00;
            mask_q  <= 8'h00;
            pend_q  <= 8'h00;
            gen_q   <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            intr_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            gen_q   <= gen_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            intr_q  <= intr_d;
        end
    end

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Scoreboard bench for io_intr_ctrl: expectations queued with stimulus,
// checked against IN_PORT/INTR on the falling clock edge.
module tb_io_intr_ctrl;

    localparam logic [7:0] A_MASK = 8'hF0;
    localparam logic [7:0] A_PEND = 8'hF1;
    localparam logic [7:0] A_ID   = 8'hF2;
    localparam logic [7:0] A_CTRL = 8'hF3;

    logic       CLK;
    logic       RESET_N;
    logic [7:0] IRQ;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] IN_PORT;
    logic       INTR;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        bit         is_intr;
        logic [7:0] addr;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];

    io_intr_ctrl #(.BASE_ADDR(8'hF0), .HOLDOFF(2)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .IRQ      (IRQ),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .IN_PORT  (IN_PORT),
        .INTR     (INTR)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
        end
    endtask

    task automatic exp_rd(input string tag, input logic [7:0] addr, input logic [7:0] val);
        exp_t e;
        e.tag = tag; e.is_intr = 1'b0; e.addr = addr; e.val = val;
        sb.push_back(e);
    endtask

    task automatic exp_intr(input string tag, input logic v);
        exp_t e;
        e.tag = tag; e.is_intr = 1'b1; e.addr = 8'h00; e.val = {7'b0, v};
        sb.push_back(e);
    endtask

    // Called on a falling edge; reads settle well before the next rising edge.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_intr) begin
                chk(e.tag, {7'b0, INTR}, e.val);
            end else begin
                PORT_ID = e.addr;
                #1;
                chk(e.tag, IN_PORT, e.val);
            end
        end
        PORT_ID = 8'h00;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        PORT_ID  = addr;
        OUT_PORT = data;
        IO_STRB  = 1'b1;
        @(negedge CLK);
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h00;
        OUT_PORT = 8'h00;
    endtask

    task automatic pulse_to_pending(input logic [7:0] m);
        IRQ = m;
        tick(1);
        IRQ = 8'h00;
        tick(2);
    endtask

    initial begin
        IRQ = 8'h00; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0; RESET_N = 1'b0;
        tick(2);
        exp_intr("rst_intr", 1'b0);
        exp_rd("rst_mask", A_MASK, 8'h00);
        exp_rd("rst_pend", A_PEND, 8'h00);
        exp_rd("rst_id",   A_ID,   8'h00);
        exp_rd("rst_ctrl", A_CTRL, 8'h00);
        drain();
        RESET_N = 1'b1;
        tick(1);

        // single masked-in source
        wr(A_CTRL, 8'h01);
        wr(A_MASK, 8'h04);
        IRQ = 8'h04; tick(1); IRQ = 8'h00; tick(1);
        exp_rd("s1_pend_early", A_PEND, 8'h00);
        exp_intr("s1_intr_early", 1'b0);
        drain();
        tick(1);
        exp_rd("s1_pend", A_PEND, 8'h04);
        exp_rd("s1_id", A_ID, 8'h82);
        exp_intr("s1_intr_pre", 1'b0);
        drain();
        tick(1);
        exp_intr("s1_intr", 1'b1);
        drain();
        wr(A_PEND, 8'h04);
        exp_rd("s1_pend_clr", A_PEND, 8'h00);
        exp_intr("s1_intr_w1", 1'b1);
        drain();
        tick(1);
        exp_intr("s1_intr_ack", 1'b0);
        exp_rd("s1_id_clr", A_ID, 8'h00);
        drain();
        tick(4);

        // two sources, priority, holdoff with an event arriving during HOLD
        wr(A_MASK, 8'hFF);
        pulse_to_pending(8'h22);
        exp_rd("s2_pend", A_PEND, 8'h22);
        exp_rd("s2_id", A_ID, 8'h81);
        drain();
        tick(1);
        exp_intr("s2_intr", 1'b1);
        drain();
        wr(A_PEND, 8'h02);
        exp_rd("s2_pend_w1c", A_PEND, 8'h20);
        exp_rd("s2_id_next", A_ID, 8'h85);
        exp_intr("s2_intr_w1c", 1'b1);
        drain();
        tick(1);
        exp_intr("s2_intr_still", 1'b1);
        drain();
        IRQ = 8'h40;
        wr(A_PEND, 8'h20);
        IRQ = 8'h00;
        exp_intr("s2_intr_b1", 1'b1);
        exp_rd("s2_pend_b1", A_PEND, 8'h00);
        drain();
        tick(1);
        exp_intr("s2_hold_b2", 1'b0);
        drain();
        tick(1);
        exp_intr("s2_hold_b3", 1'b0);
        exp_rd("s2_latched", A_PEND, 8'h40);
        drain();
        tick(1);
        exp_intr("s2_idle_b4", 1'b0);
        drain();
        tick(1);
        exp_intr("s2_refire", 1'b1);
        exp_rd("s2_id_refire", A_ID, 8'h86);
        drain();
        wr(A_PEND, 8'h40);
        tick(5);

        // edge coinciding with W1C of the same bit
        pulse_to_pending(8'h08);
        exp_rd("s3_pend", A_PEND, 8'h08);
        drain();
        IRQ = 8'h08; tick(1); IRQ = 8'h00; tick(1);
        wr(A_PEND, 8'h08);
        exp_rd("s3_set_wins", A_PEND, 8'h08);
        exp_intr("s3_intr", 1'b1);
        drain();
        wr(A_PEND, 8'h08);
        exp_rd("s3_w1c", A_PEND, 8'h00);
        drain();
        tick(5);

        // masked source latches; unmasking fires; masking acknowledges
        wr(A_MASK, 8'h00);
        pulse_to_pending(8'h80);
        exp_rd("s4_pend", A_PEND, 8'h80);
        exp_rd("s4_id_masked", A_ID, 8'h00);
        exp_intr("s4_intr_masked", 1'b0);
        drain();
        tick(1);
        exp_intr("s4_intr_masked2", 1'b0);
        drain();
        wr(A_MASK, 8'h80);
        exp_rd("s4_mask", A_MASK, 8'h80);
        exp_rd("s4_id", A_ID, 8'h87);
        drain();
        tick(1);
        exp_intr("s4_intr_unmask", 1'b1);
        drain();
        wr(A_MASK, 8'h00);
        tick(1);
        exp_intr("s4_mask_ack", 1'b0);
        exp_rd("s4_pend_kept", A_PEND, 8'h80);
        drain();
        wr(A_PEND, 8'h80);
        tick(5);

        // decode: unselected port, read-only ID, CTRL reserved bits
        wr(8'h10, 8'hFF);
        exp_rd("s5_nosel", 8'h10, 8'h00);
        exp_rd("s5_mask", A_MASK, 8'h00);
        exp_rd("s5_pend", A_PEND, 8'h00);
        exp_rd("s5_ctrl", A_CTRL, 8'h01);
        drain();
        wr(A_ID, 8'hFF);
        exp_rd("s5_id_ro", A_ID, 8'h00);
        exp_rd("s5_mask_id", A_MASK, 8'h00);
        drain();
        wr(A_CTRL, 8'hFF);
        wr(A_MASK, 8'h5A);
        exp_rd("s5_ctrl_rsvd", A_CTRL, 8'h01);
        exp_rd("s5_mask_rw", A_MASK, 8'h5A);
        exp_rd("s5_below", 8'hEF, 8'h00);
        exp_rd("s5_above", 8'hF4, 8'h00);
        drain();

        // global enable gating
        wr(A_MASK, 8'hFF);
        wr(A_CTRL, 8'h00);
        pulse_to_pending(8'h01);
        exp_rd("s6_pend", A_PEND, 8'h01);
        exp_rd("s6_id", A_ID, 8'h80);
        drain();
        tick(2);
        exp_intr("s6_gen_off", 1'b0);
        drain();
        wr(A_CTRL, 8'h01);
        tick(1);
        exp_intr("s6_gen_on", 1'b1);
        drain();
        wr(A_CTRL, 8'h00);
        tick(1);
        exp_intr("s6_gen_ack", 1'b0);
        exp_rd("s6_pend_kept", A_PEND, 8'h01);
        drain();
        wr(A_PEND, 8'h01);
        tick(5);

        // reset during FIRE; IRQ held high through release
        wr(A_CTRL, 8'h01);
        pulse_to_pending(8'h10);
        tick(1);
        exp_intr("s7_fire", 1'b1);
        drain();
        RESET_N = 1'b0;
        #1;
        exp_intr("s7_async", 1'b0);
        exp_rd("s7_rst_pend", A_PEND, 8'h00);
        exp_rd("s7_rst_mask", A_MASK, 8'h00);
        exp_rd("s7_rst_ctrl", A_CTRL, 8'h00);
        drain();
        IRQ = 8'h02;
        tick(1);
        RESET_N = 1'b1;
        tick(2);
        exp_rd("s7_pend_r2", A_PEND, 8'h00);
        drain();
        tick(1);
        exp_rd("s7_pend_r3", A_PEND, 8'h02);
        exp_intr("s7_intr_r3", 1'b0);
        drain();
        tick(4);
        exp_rd("s7_pend_r7", A_PEND, 8'h02);
        exp_intr("s7_intr_r7", 1'b0);
        drain();
        wr(A_PEND, 8'h02);
        tick(4);
        exp_rd("s7_one_event", A_PEND, 8'h00);
        drain();
        IRQ = 8'h00;
        tick(3);
        wr(A_CTRL, 8'h01);
        wr(A_MASK, 8'hFF);
        tick(2);
        exp_intr("s7_quiet", 1'b0);
        drain();
        pulse_to_pending(8'h40);
        tick(1);
        exp_intr("s7_new_edge", 1'b1);
        exp_rd("s7_new_id", A_ID, 8'h86);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
